// File: rtl/mig_if_pkg.sv
// Shared types and constants for the MIG command issuer: app command codes,
// command-entry layout and issue FSM state encoding.
package mig_if_pkg;

    localparam int DEF_DW = 128;
    localparam int DEF_AW = 28;
    localparam int DEF_MW = DEF_DW / 8;

    localparam logic [2:0] APP_CMD_RD = 3'b001;
    localparam logic [2:0] APP_CMD_WR = 3'b000;

    // Entry layout, MSB first: {rw, addr, mask, wdata}
    function automatic int cq_w(input int aw, input int mw, input int dw);
        return 1 + aw + mw + dw;
    endfunction

    function automatic int cq_rw_bit(input int aw, input int mw, input int dw);
        return aw + mw + dw;
    endfunction

    function automatic int cq_addr_lsb(input int mw, input int dw);
        return mw + dw;
    endfunction

    function automatic int cq_mask_lsb(input int dw);
        return dw;
    endfunction

    localparam int CQ_W = 1 + DEF_AW + DEF_MW + DEF_DW;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/mig_rd_return.sv
// Read-return path: tracks outstanding reads, registers MIG read data into the return FIFO (1 cycle).
// MIG cannot be stalled, so data arriving while the FIFO is full is dropped and flagged sticky in ovf_err.
module mig_rd_return #(
    parameter int DW         = 128,
    parameter int MAX_RD_OUT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_issue,
    input  logic          app_rd_data_valid,
    input  logic [DW-1:0] app_rd_data,
    input  logic          rq_wqfull,
    output logic          rq_wen,
    output logic [DW-1:0] rq_wdata,
    output logic          ovf_err,
    output logic          rd_room
);

    localparam int CW = $clog2(MAX_RD_OUT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_RD_OUT);

    logic [CW-1:0] rd_out_q, rd_out_d;
    logic          rq_wen_q, rq_wen_d;
    logic [DW-1:0] rq_wdata_q, rq_wdata_d;
    logic          ovf_err_q, ovf_err_d;

    always_comb begin
        rd_out_d   = rd_out_q;
        ovf_err_d  = ovf_err_q;
        rq_wen_d   = app_rd_data_valid & ~rq_wqfull;
        rq_wdata_d = rq_wdata_q;

        if (rd_issue && !app_rd_data_valid) begin
            rd_out_d = rd_out_q + 1'b1;
        end else if (!rd_issue && app_rd_data_valid) begin
            // A return with nothing outstanding means accounting is broken.
            if (rd_out_q == '0) begin
                ovf_err_d = 1'b1;
            end else begin
                rd_out_d = rd_out_q - 1'b1;
            end
        end

        if (app_rd_data_valid) begin
            rq_wdata_d = app_rd_data;
            if (rq_wqfull) begin
                ovf_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_out_q   <= '0;
            rq_wen_q   <= 1'b0;
            rq_wdata_q <= '0;
            ovf_err_q  <= 1'b0;
        end else begin
            rd_out_q   <= rd_out_d;
            rq_wen_q   <= rq_wen_d;
            rq_wdata_q <= rq_wdata_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    assign rq_wen   = rq_wen_q;
    assign rq_wdata = rq_wdata_q;
    assign ovf_err  = ovf_err_q;
    assign rd_room  = (rd_out_q < MAX_C);

endmodule

// File: rtl/mig_cmd_issuer.sv
// Pops command-FIFO entries and drives the MIG app command/write-data channels; app_en 1 cycle after pop.
// Holds app_en/app_wdf_wren until accepted; reads are not popped while MAX_RD_OUT are outstanding or the return FIFO is full.
module mig_cmd_issuer
    import mig_if_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int AW         = DEF_AW,
    parameter int MW         = DW / 8,
    parameter int MAX_RD_OUT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cq_rqempty,
    input  logic [AW+MW+DW:0] cq_rdata,
    output logic              cq_rnext,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [AW-1:0]     app_addr,
    input  logic              app_rdy,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [DW-1:0]     app_wdf_data,
    output logic [MW-1:0]     app_wdf_mask,
    input  logic              app_wdf_rdy,
    input  logic              app_rd_data_valid,
    input  logic [DW-1:0]     app_rd_data,
    output logic              rq_wen,
    output logic [DW-1:0]     rq_wdata,
    input  logic              rq_wqfull,
    output logic              ovf_err
);

    localparam int RW_BIT   = cq_rw_bit(AW, MW, DW);
    localparam int ADDR_LSB = cq_addr_lsb(MW, DW);
    localparam int MASK_LSB = cq_mask_lsb(DW);

    state_e        state_q, state_d;
    logic          cmd_done_q, cmd_done_d;
    logic          wdf_done_q, wdf_done_d;
    logic          is_rd_q, is_rd_d;
    logic [2:0]    cmd_q, cmd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [MW-1:0] mask_q, mask_d;
    logic [DW-1:0] data_q, data_d;

    logic entry_rw, pop_ok, pop, cmd_acc, wdf_acc, rd_room;

    assign entry_rw     = cq_rdata[RW_BIT];
    assign pop_ok       = ~cq_rqempty & (~entry_rw | (rd_room & ~rq_wqfull));
    assign app_en       = (state_q == ISSUE) & ~cmd_done_q;
    assign app_wdf_wren = (state_q == ISSUE) & ~wdf_done_q;
    assign app_wdf_end  = app_wdf_wren;
    assign cmd_acc      = app_en & app_rdy;
    assign wdf_acc      = app_wdf_wren & app_wdf_rdy;

    always_comb begin
        state_d    = state_q;
        cmd_done_d = cmd_done_q;
        wdf_done_d = wdf_done_q;
        is_rd_d    = is_rd_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        data_d     = data_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop_ok) begin
                    pop        = 1'b1;
                    is_rd_d    = entry_rw;
                    cmd_d      = entry_rw ? APP_CMD_RD : APP_CMD_WR;
                    addr_d     = cq_rdata[ADDR_LSB +: AW];
                    mask_d     = cq_rdata[MASK_LSB +: MW];
                    data_d     = cq_rdata[DW-1:0];
                    cmd_done_d = 1'b0;
                    // Reads carry no write data, so that channel is done up front.
                    wdf_done_d = entry_rw;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_acc) cmd_done_d = 1'b1;
                if (wdf_acc) wdf_done_d = 1'b1;
                if ((cmd_done_q | cmd_acc) && (wdf_done_q | wdf_acc)) begin
                    cmd_done_d = 1'b0;
                    wdf_done_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_done_q <= 1'b0;
            wdf_done_q <= 1'b0;
            is_rd_q    <= 1'b0;
            cmd_q      <= '0;
            addr_q     <= '0;
            mask_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cmd_done_q <= cmd_done_d;
            wdf_done_q <= wdf_done_d;
            is_rd_q    <= is_rd_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
        end
    end

    assign cq_rnext     = pop & ~rst;
    assign app_cmd      = cmd_q;
    assign app_addr     = addr_q;
    assign app_wdf_data = data_q;
    assign app_wdf_mask = mask_q;

    mig_rd_return #(
        .DW         (DW),
        .MAX_RD_OUT (MAX_RD_OUT)
    ) u_rd_return (
        .clk               (clk),
        .rst               (rst),
        .rd_issue          (cmd_acc & is_rd_q),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data       (app_rd_data),
        .rq_wqfull         (rq_wqfull),
        .rq_wen            (rq_wen),
        .rq_wdata          (rq_wdata),
        .ovf_err           (ovf_err),
        .rd_room           (rd_room)
    );

endmodule

// File: tb/tb_mig_cmd_issuer.sv
// Self-checking bench for mig_cmd_issuer: command-FIFO model, scoreboard of expected
// app commands / write data / return data, table-driven vectors plus corner sequences.
module tb_mig_cmd_issuer;
    import mig_if_pkg::*;

    localparam int DW = 128;
    localparam int AW = 28;
    localparam int MW = 16;
    localparam int EW = 1 + AW + MW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cq_rqempty = 1'b1;
    logic [EW-1:0] cq_rdata = '0;
    logic          cq_rnext;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_rdy = 1'b1;
    logic          app_wdf_wren, app_wdf_end;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_wdf_rdy = 1'b1;
    logic          app_rd_data_valid = 1'b0;
    logic [DW-1:0] app_rd_data = '0;
    logic          rq_wen;
    logic [DW-1:0] rq_wdata;
    logic          rq_wqfull = 1'b0;
    logic          ovf_err;

    mig_cmd_issuer #(.DW(DW), .AW(AW), .MW(MW), .MAX_RD_OUT(2)) dut (
        .clk(clk), .rst(rst), .cq_rqempty(cq_rqempty), .cq_rdata(cq_rdata), .cq_rnext(cq_rnext),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
        .rq_wen(rq_wen), .rq_wdata(rq_wdata), .rq_wqfull(rq_wqfull), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int en_cyc = 0;
    int wren_cyc = 0;
    logic pop_pend = 1'b0;

    logic [EW-1:0] cq_q[$];
    logic [EW-1:0] exp_cmd[$];
    logic [EW-1:0] exp_wdf[$];
    logic [DW-1:0] ret_q[$];

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] data;
        int            rdy_dly;
        int            wdf_dly;
        int            exp_en;
        int            exp_wren;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cq();
        cq_rqempty = (cq_q.size() == 0);
        cq_rdata   = (cq_q.size() == 0) ? '0 : cq_q[0];
    endtask

    task automatic push_cmd(input logic rw, input logic [AW-1:0] addr,
                            input logic [MW-1:0] mask, input logic [DW-1:0] data);
        logic [EW-1:0] e;
        e = {rw, addr, mask, data};
        cq_q.push_back(e);
        exp_cmd.push_back(e);
        if (!rw) exp_wdf.push_back(e);
        drive_cq();
    endtask

    // Sample just after the inputs settle, then advance one clock to the next falling edge.
    task automatic monitor();
        logic [EW-1:0] e;
        pop_pend = cq_rnext;
        if (cq_rnext && cq_q.size() == 0) chk("pop_when_empty", 1'b1, 1'b0);
        if (app_en) begin
            en_cyc++;
            if (exp_cmd.size() == 0) chk("unexpected_app_en", 1'b1, 1'b0);
            else begin
                e = exp_cmd[0];
                chk("app_cmd", app_cmd, e[EW-1] ? 3'b001 : 3'b000);
                chk("app_addr", app_addr, e[EW-2 -: AW]);
                if (app_rdy) void'(exp_cmd.pop_front());
            end
        end
        if (app_wdf_wren) begin
            wren_cyc++;
            chk("app_wdf_end", app_wdf_end, 1'b1);
            if (exp_wdf.size() == 0) chk("unexpected_wdf_wren", 1'b1, 1'b0);
            else begin
                e = exp_wdf[0];
                chk("app_wdf_data", app_wdf_data, e[DW-1:0]);
                chk("app_wdf_mask", app_wdf_mask, e[DW +: MW]);
                if (app_wdf_rdy) void'(exp_wdf.pop_front());
            end
        end
        if (rq_wen) begin
            if (ret_q.size() == 0) chk("unexpected_rq_wen", 1'b1, 1'b0);
            else chk("rq_wdata", rq_wdata, ret_q.pop_front());
        end
    endtask

    task automatic step();
        #1;
        monitor();
        @(posedge clk);
        #1;
        if (pop_pend && cq_q.size() != 0) begin
            void'(cq_q.pop_front());
            pops++;
        end
        pop_pend = 1'b0;
        drive_cq();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((dut.state_q != IDLE || cq_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("wait_idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic rd_return(input logic [DW-1:0] d, input logic full);
        app_rd_data_valid = 1'b1;
        app_rd_data       = d;
        rq_wqfull         = full;
        if (!full) ret_q.push_back(d);
        step();
        app_rd_data_valid = 1'b0;
        rq_wqfull         = 1'b0;
    endtask

    task automatic flush_exp();
        exp_cmd.delete();
        exp_wdf.delete();
        ret_q.delete();
    endtask

    initial begin
        int p0;
        logic [DW-1:0] d;

        vecs[0] = '{1'b0, 28'h0000200, 16'h0000, {4{32'hDEADBEEF}}, 0, 0, 1, 1};
        vecs[1] = '{1'b1, 28'h0ABCDE0, 16'h0000, 128'h0,            0, 0, 1, 0};
        vecs[2] = '{1'b0, 28'hFFFFFFF, 16'hFFFF, {128{1'b1}},       2, 0, 3, 1};
        vecs[3] = '{1'b0, 28'h0000010, 16'h00F0, 128'h0123456789ABCDEF_FEDCBA9876543210, 0, 3, 1, 4};
        vecs[4] = '{1'b1, 28'h1234567, 16'h0000, 128'h0,            4, 0, 5, 0};
        vecs[5] = '{1'b0, 28'h8000000, 16'h8001, 128'h5A5A,         1, 1, 2, 2};

        // Reset state
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("rst_app_en", app_en, 1'b0);
        chk("rst_app_wdf_wren", app_wdf_wren, 1'b0);
        chk("rst_app_wdf_end", app_wdf_end, 1'b0);
        chk("rst_cq_rnext", cq_rnext, 1'b0);
        chk("rst_rq_wen", rq_wen, 1'b0);
        chk("rst_ovf_err", ovf_err, 1'b0);
        chk("rst_app_cmd", app_cmd, 3'b000);
        chk("rst_app_addr", app_addr, 28'h0);
        chk("rst_state", dut.state_q, IDLE);
        chk("rst_rd_out", dut.u_rd_return.rd_out_q, 0);

        // Single write
        push_cmd(1'b0, 28'h0000100, 16'h0000, {16{8'hA5}});
        #1;
        chk("sw_cq_rnext_t", cq_rnext, 1'b1);
        step();
        chk("sw_app_en_t1", app_en, 1'b1);
        chk("sw_wren_t1", app_wdf_wren, 1'b1);
        chk("sw_end_t1", app_wdf_end, 1'b1);
        chk("sw_cmd_t1", app_cmd, 3'b000);
        chk("sw_addr_t1", app_addr, 28'h100);
        chk("sw_cq_rnext_t1", cq_rnext, 1'b0);
        step();
        chk("sw_state_t2", dut.state_q, IDLE);
        chk("sw_app_en_t2", app_en, 1'b0);

        // Stalled write
        en_cyc = 0; wren_cyc = 0; p0 = pops;
        push_cmd(1'b0, 28'h0000333, 16'h0F0F, 128'hCAFE_F00D);
        step();
        for (int c = 0; c < 12; c++) begin
            app_rdy     = (c >= 3);
            app_wdf_rdy = (c >= 5);
            step();
        end
        chk("stall_en_cycles", en_cyc, 4);
        chk("stall_wren_cycles", wren_cyc, 6);
        chk("stall_pops", pops - p0, 1);
        chk("stall_state", dut.state_q, IDLE);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            en_cyc = 0; wren_cyc = 0; p0 = pops;
            push_cmd(vecs[i].rw, vecs[i].addr, vecs[i].mask, vecs[i].data);
            step();
            for (int c = 0; c < 12; c++) begin
                app_rdy     = (c >= vecs[i].rdy_dly);
                app_wdf_rdy = (c >= vecs[i].wdf_dly);
                step();
            end
            chk($sformatf("vec%0d_en_cycles", i), en_cyc, vecs[i].exp_en);
            chk($sformatf("vec%0d_wren_cycles", i), wren_cyc, vecs[i].exp_wren);
            chk($sformatf("vec%0d_pops", i), pops - p0, 1);
            if (vecs[i].rw) begin
                d = ~(DW'(vecs[i].addr));
                rd_return(d, 1'b0);
                step();
                chk($sformatf("vec%0d_rd_out", i), dut.u_rd_return.rd_out_q, 0);
            end
        end

        // Read limit and return path
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; p0 = pops;
        push_cmd(1'b1, 28'h0000A00, 16'h0, 128'h0);
        push_cmd(1'b1, 28'h0000A10, 16'h0, 128'h0);
        push_cmd(1'b1, 28'h0000A20, 16'h0, 128'h0);
        for (int c = 0; c < 10; c++) step();
        chk("rl_pops_two", pops - p0, 2);
        chk("rl_rd_out_two", dut.u_rd_return.rd_out_q, 2);
        chk("rl_third_blocked", cq_rnext, 1'b0);
        rd_return(128'h1234, 1'b0);
        chk("ret_rq_wen", rq_wen, 1'b1);
        chk("ret_rq_wdata", rq_wdata, 128'h1234);
        chk("ret_rd_out_dec", dut.u_rd_return.rd_out_q, 1);
        chk("rl_third_pops_now", cq_rnext, 1'b1);
        wait_idle(20);
        step();
        chk("rl_pops_three", pops - p0, 3);
        chk("rl_rd_out_after", dut.u_rd_return.rd_out_q, 2);
        rd_return(128'hBEEF0001, 1'b0);
        rd_return(128'hBEEF0002, 1'b0);
        step();
        chk("rl_drained", dut.u_rd_return.rd_out_q, 0);

        // Overflow: return FIFO full
        push_cmd(1'b1, 28'h0000B00, 16'h0, 128'h0);
        wait_idle(20);
        step();
        chk("ovf_pre_rd_out", dut.u_rd_return.rd_out_q, 1);
        chk("ovf_pre_err", ovf_err, 1'b0);
        rd_return(128'h77, 1'b1);
        chk("ovf_rq_wen", rq_wen, 1'b0);
        chk("ovf_err_set", ovf_err, 1'b1);
        for (int c = 0; c < 5; c++) step();
        chk("ovf_err_sticky", ovf_err, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ovf_err_rst", ovf_err, 1'b0);

        // Underflow: return with nothing outstanding
        rd_return(128'h55, 1'b0);
        chk("unf_rq_wen", rq_wen, 1'b1);
        chk("unf_ovf_err", ovf_err, 1'b1);
        chk("unf_rd_out", dut.u_rd_return.rd_out_q, 0);

        // Reset mid-issue
        push_cmd(1'b1, 28'h0000C00, 16'h0, 128'h0);
        wait_idle(20);
        app_rdy = 1'b0;
        push_cmd(1'b1, 28'h0000C10, 16'h0, 128'h0);
        step();
        step();
        chk("rmi_in_issue", dut.state_q, ISSUE);
        chk("rmi_rd_out_pre", dut.u_rd_return.rd_out_q, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        flush_exp();
        chk("rmi_app_en", app_en, 1'b0);
        chk("rmi_rd_out", dut.u_rd_return.rd_out_q, 0);
        chk("rmi_ovf_err", ovf_err, 1'b0);
        chk("rmi_state", dut.state_q, IDLE);
        app_rdy = 1'b1; en_cyc = 0; p0 = pops;
        for (int c = 0; c < 5; c++) step();
        chk("rmi_no_reissue", en_cyc, 0);
        chk("rmi_no_pop", pops - p0, 0);

        chk("sb_cmd_empty", exp_cmd.size(), 0);
        chk("sb_wdf_empty", exp_wdf.size(), 0);
        chk("sb_ret_empty", ret_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
